ram_cmd_arbiter: RTL and testbench

Sequences and shares the 256x8 command-driven RAM between two independent requesters. Each requester issues whole read or write transactions over a valid/ready port. The block arbitrates round-robin, translates each transaction into the RAM's 10-bit command stream (write-address, write-data, read-address, read-issue), waits for the RAM's `tx_valid`, and returns a response to the owning requester. It sits between the SPI slave front end (requester 0) and a secondary host/debug port (requester 1) on one side, and the RAM `din`/`rx_valid`/`tx_valid`/`dout` pins on the other.

---
 rtl/ram_cmd_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// Two-port round-robin front end for the 256x8 command-driven RAM.
// Turns whole read/write transactions into the RAM's 10-bit command stream.
module ram_cmd_arbiter #(
  parameter int unsigned RD_TIMEOUT = 15,
  parameter bit          ADDR_CACHE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_wr,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_wr,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_err,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic       ram_tx_valid,
  input  logic [7:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WAIT, S_RESP
  } state_e;

  localparam logic [7:0] TMO   = 8'(RD_TIMEOUT);
  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RI = 2'b11;

  state_e     state_q, state_d;
  logic       own_q, own_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lg_q, lg_d;
  logic [7:0] wca_q, wca_d;
  logic       wcv_q, wcv_d;
  logic [7:0] rca_q, rca_d;
  logic       rcv_q, rcv_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic [9:0] din_q, din_d;
  logic       rxv_q, rxv_d;
  logic [1:0] rsp_q, rsp_d;

  logic       idle, gnt, acc, done;
  logic       sel_wr, hit;
  logic [7:0] sel_addr, sel_wdata;
  logic [9:0] sel_dcmd, q_dcmd;

  // Both valid: the side not served last wins; else the lone valid side.
  assign idle = (state_q == S_IDLE);
  assign gnt  = (req0_valid & req1_valid) ? ~lg_q : req1_valid;
  assign acc  = rst_n & idle & (req0_valid | req1_valid);

  assign req0_ready = acc & ~gnt;
  assign req1_ready = acc & gnt;

  assign sel_wr    = gnt ? req1_wr    : req0_wr;
  assign sel_addr  = gnt ? req1_addr  : req0_addr;
  assign sel_wdata = gnt ? req1_wdata : req0_wdata;

  assign hit = ADDR_CACHE & (sel_wr
             ? (wcv_q & (wca_q == sel_addr))
             : (rcv_q & (rca_q == sel_addr)));

  assign sel_dcmd = sel_wr ? {OP_WD, sel_wdata} : {OP_RI, 8'h00};
  assign q_dcmd   = wr_q   ? {OP_WD, wdata_q}   : {OP_RI, 8'h00};

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    lg_d    = lg_q;
    wca_d   = wca_q;
    wcv_d   = wcv_q;
    rca_d   = rca_q;
    rcv_d   = rcv_q;
    rdata_d = 8'h00;
    err_d   = 1'b0;
    din_d   = '0;
    rxv_d   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          own_d   = gnt;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rxv_d   = 1'b1;
          if (hit) begin
            state_d = S_DATA;
            din_d   = sel_dcmd;
            cnt_d   = '0;
          end else begin
            state_d = S_ADDR;
            din_d   = {sel_wr ? OP_WA : OP_RA, sel_addr};
          end
        end
      end
      S_ADDR: begin
        if (wr_q) begin
          wca_d = addr_q;
          wcv_d = 1'b1;
        end else begin
          rca_d = addr_q;
          rcv_d = 1'b1;
        end
        state_d = S_DATA;
        din_d   = q_dcmd;
        rxv_d   = 1'b1;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (wr_q) begin
          state_d = S_RESP;
          done    = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          state_d = S_RESP;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // A timed-out read leaves the RAM read address in doubt.
          if (cnt_q + 8'd1 == TMO) begin
            err_d   = 1'b1;
            rcv_d   = 1'b0;
            state_d = S_RESP;
            done    = 1'b1;
          end
        end
      end
      S_RESP: begin
        lg_d    = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rsp_d = done ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      lg_q    <= 1'b1;
      wca_q   <= '0;
      wcv_q   <= 1'b0;
      rca_q   <= '0;
      rcv_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      lg_q    <= lg_d;
      wca_q   <= wca_d;
      wcv_q   <= wcv_d;
      rca_q   <= rca_d;
      rcv_q   <= rcv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      din_q   <= din_d;
      rxv_q   <= rxv_d;
      rsp_q   <= rsp_d;
    end
  end

  assign ram_din      = din_q & {10{rst_n}};
  assign ram_rx_valid = rxv_q & rst_n;
  assign rsp0_valid   = rsp_q[0] & rst_n;
  assign rsp1_valid   = rsp_q[1] & rst_n;
  assign rsp0_rdata   = rsp0_valid ? rdata_q : 8'h00;
  assign rsp1_rdata   = rsp1_valid ? rdata_q : 8'h00;
  assign rsp0_err     = rsp0_valid & err_q;
  assign rsp1_err     = rsp1_valid & err_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Random two-requester traffic against a transaction-level schedule model,
// plus a short directed run on an uncached, short-timeout instance.
module tb_ram_cmd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req0_ready, req0_wr;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_wr;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid;
  logic [7:0] ram_dout;

  logic       nc0_valid, nc0_ready, nc0_wr;
  logic [7:0] nc0_addr, nc0_wdata;
  logic       nc1_valid, nc1_ready, nc1_wr;
  logic [7:0] nc1_addr, nc1_wdata;
  logic       ncr0_valid, ncr0_err, ncr1_valid, ncr1_err;
  logic [7:0] ncr0_rdata, ncr1_rdata;
  logic [9:0] nc_din;
  logic       nc_rxv, nc_txv;
  logic [7:0] nc_dout;

  ram_cmd_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
  );

  ram_cmd_arbiter #(.RD_TIMEOUT(3), .ADDR_CACHE(1'b0)) u_nc (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(nc0_valid), .req0_ready(nc0_ready),
    .req0_wr(nc0_wr), .req0_addr(nc0_addr),
    .req0_wdata(nc0_wdata),
    .req1_valid(nc1_valid), .req1_ready(nc1_ready),
    .req1_wr(nc1_wr), .req1_addr(nc1_addr),
    .req1_wdata(nc1_wdata),
    .rsp0_valid(ncr0_valid), .rsp0_rdata(ncr0_rdata),
    .rsp0_err(ncr0_err),
    .rsp1_valid(ncr1_valid), .rsp1_rdata(ncr1_rdata),
    .rsp1_err(ncr1_err),
    .ram_din(nc_din), .ram_rx_valid(nc_rxv),
    .ram_tx_valid(nc_txv), .ram_dout(nc_dout)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  // Reference model: memory, caches and the expected cycle schedule.
  logic [7:0] ref_mem [256];
  logic [7:0] ram_mem [256];
  int         free_cyc, a_cyc, d_cyc, r_cyc;
  logic [9:0] a_cmd, d_cmd;
  logic       r_own, r_err, d_wr;
  logic [7:0] r_data, d_addr, d_wdata;
  logic       lg, wv, rv;
  logic [7:0] wa, ra;
  logic [7:0] fw_a, fr_a;
  logic       pend, mute, acc0, acc1;

  task automatic model_reset();
    a_cyc    = -1;
    d_cyc    = -1;
    r_cyc    = -1;
    wv       = 1'b0;
    rv       = 1'b0;
    lg       = 1'b1;
    free_cyc = cyc + 1;
  endtask

  task automatic accept(input logic own);
    logic       wr, hit;
    logic [7:0] a, wd;
    int         o;
    wr  = own ? req1_wr    : req0_wr;
    a   = own ? req1_addr  : req0_addr;
    wd  = own ? req1_wdata : req0_wdata;
    hit = wr ? (wv && wa == a) : (rv && ra == a);
    o   = 1;
    a_cyc = -1;
    if (!hit) begin
      a_cyc = cyc + 1;
      a_cmd = {wr ? 2'b00 : 2'b10, a};
      if (wr) begin wv = 1'b1; wa = a; end
      else begin rv = 1'b1; ra = a; end
      o = 2;
    end
    d_cyc   = cyc + o;
    d_cmd   = wr ? {2'b01, wd} : 10'h300;
    d_wr    = wr;
    d_addr  = a;
    d_wdata = wd;
    r_err   = 1'b0;
    r_data  = 8'h00;
    if (wr) begin
      r_cyc = cyc + o + 1;
    end else if (!mute) begin
      r_cyc  = cyc + o + 2;
      r_data = ref_mem[a];
    end else begin
      r_cyc = cyc + o + 1 + 15;
      r_err = 1'b1;
      rv    = 1'b0;
    end
    r_own    = own;
    lg       = own;
    free_cyc = r_cyc + 1;
  endtask

  task automatic check_cycle();
    logic       idle, e0, e1;
    logic [10:0] ecmd;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (!rst_n) begin
      chk("rst_outs",
          64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_err, rsp1_err, ram_rx_valid, ram_din,
               rsp0_rdata, rsp1_rdata}), 64'd0);
      model_reset();
      return;
    end
    idle = (cyc >= free_cyc);
    e0 = idle && req0_valid && (!req1_valid || lg);
    e1 = idle && req1_valid && (!req0_valid || !lg);
    chk("ready0", 64'(req0_ready), 64'(e0));
    chk("ready1", 64'(req1_ready), 64'(e1));
    ecmd = 11'd0;
    if (cyc == a_cyc) ecmd = {1'b1, a_cmd};
    if (cyc == d_cyc) ecmd = {1'b1, d_cmd};
    chk("ram_cmd", 64'({ram_rx_valid, ram_din}), 64'(ecmd));
    if (cyc == d_cyc && d_wr) ref_mem[d_addr] = d_wdata;
    chk("rsp_valid", 64'({rsp1_valid, rsp0_valid}),
        64'((cyc == r_cyc) ? (r_own ? 2'b10 : 2'b01) : 2'b00));
    if (cyc == r_cyc) begin
      chk("rsp_rdata",
          64'(r_own ? rsp1_rdata : rsp0_rdata), 64'(r_data));
      chk("rsp_err",
          64'(r_own ? rsp1_err : rsp0_err), 64'(r_err));
      chk("rsp_other",
          64'(r_own ? {rsp0_rdata, rsp0_err}
                    : {rsp1_rdata, rsp1_err}), 64'd0);
    end
    if (e0 || e1) accept(e1);
  endtask

  task automatic ram_step();
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: fw_a = ram_din[7:0];
        2'b01: ram_mem[fw_a] = ram_din[7:0];
        2'b10: fr_a = ram_din[7:0];
        default: pend = !mute;
      endcase
    end
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(5))
      0: return 8'h12;
      1: return 8'h13;
      2: return 8'h01;
      3: return 8'h02;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic new_req(output logic v, output logic w,
                         output logic [7:0] a,
                         output logic [7:0] d);
    v = ($urandom_range(3) != 0);
    w = 1'($urandom_range(1));
    a = pick_addr();
    d = 8'($urandom);
  endtask

  task automatic drive_main();
    rst_n = (cyc > 4) &&
            !(cyc > 30 && cyc < free_cyc &&
              $urandom_range(49) == 0);
    if (pend) begin
      ram_tx_valid = 1'b1;
      ram_dout     = ram_mem[fr_a];
      pend         = 1'b0;
    end else begin
      ram_tx_valid = 1'b0;
      ram_dout     = 8'($urandom);
    end
    if (!req0_valid || acc0)
      new_req(req0_valid, req0_wr, req0_addr, req0_wdata);
    if (!req1_valid || acc1)
      new_req(req1_valid, req1_wr, req1_addr, req1_wdata);
    if (cyc >= free_cyc) mute = ($urandom_range(5) == 0);
  endtask

  task automatic nc_step();
    @(posedge clk);
    #1;
    cyc++;
    nc0_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {req0_valid, req0_wr, req0_addr, req0_wdata} = '0;
    {req1_valid, req1_wr, req1_addr, req1_wdata} = '0;
    {nc0_valid, nc0_wr, nc0_addr, nc0_wdata} = '0;
    {nc1_valid, nc1_wr, nc1_addr, nc1_wdata} = '0;
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    nc_txv       = 1'b0;
    nc_dout      = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      ram_mem[i] = 8'h00;
    end
    fw_a = 8'h00;
    fr_a = 8'h00;
    pend = 1'b0;
    mute = 1'b0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    model_reset();

    repeat (3000) begin
      @(posedge clk);
      #1;
      cyc++;
      drive_main();
      @(negedge clk);
      check_cycle();
      ram_step();
    end

    // Quiesce, then run the uncached instance alone.
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++) begin
      nc0_valid = 1'b1;
      nc0_wr    = 1'b1;
      nc0_addr  = 8'h40;
      nc0_wdata = (k == 0) ? 8'h11 : 8'h22;
      @(negedge clk);
      chk("nc_ready", 64'(nc0_ready), 64'd1);
      nc_step();
      @(negedge clk);
      chk("nc_addr", 64'({nc_rxv, nc_din}), 64'h440);
      nc_step();
      @(negedge clk);
      chk("nc_data", 64'({nc_rxv, nc_din}),
          64'({3'b101, nc0_wdata}));
      nc_step();
      @(negedge clk);
      chk("nc_wrsp", 64'({ncr0_valid, ncr0_err, ncr0_rdata}),
          64'h200);
      nc_step();
    end

    nc0_valid = 1'b1;
    nc0_wr    = 1'b0;
    nc0_addr  = 8'h40;
    @(negedge clk);
    chk("nc_rd_ready", 64'(nc0_ready), 64'd1);
    nc_step();
    @(negedge clk);
    chk("nc_rd_addr", 64'({nc_rxv, nc_din}), 64'h640);
    nc_step();
    @(negedge clk);
    chk("nc_rd_issue", 64'({nc_rxv, nc_din}), 64'h700);
    for (int w = 0; w < 3; w++) begin
      nc_step();
      @(negedge clk);
      chk("nc_wait", 64'({ncr0_valid, nc_rxv}), 64'd0);
    end
    nc_step();
    @(negedge clk);
    chk("nc_tmo", 64'({ncr0_valid, ncr0_err, ncr0_rdata}),
        64'h300);
    chk("nc_other", 64'({ncr1_valid, ncr1_err}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
